// File: rtl/io_mux_pkg.sv
// Shared types and constants for the IO mux break-before-make sequencer.
package io_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] FUN_A = 2'b00;
    localparam logic [SEL_W-1:0] FUN_B = 2'b01;
    localparam logic [SEL_W-1:0] FUN_C = 2'b10;
    localparam logic [SEL_W-1:0] FUN_D = 2'b11;

    localparam int GUARD_W = 8;

endpackage

// File: rtl/io_mux_guard_cnt.sv
// Loadable down counter timing the gate and settle guard intervals.
module io_mux_guard_cnt
    import io_mux_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [GUARD_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [GUARD_W-1:0] cnt_q;
    logic [GUARD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - GUARD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/io_mux_sel_ctrl.sv
// Break-before-make select sequencer for a bank of IO mux cells.
// Optional per-pin lock enabled by defining IO_MUX_CTRL_LOCK_EN.
module io_mux_sel_ctrl
    import io_mux_pkg::*;
#(
    parameter int NUM_PIN   = 8,
    parameter int PIN_W     = $clog2(NUM_PIN),
    parameter int GUARD_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             testmode,
    input  logic                   cfg_vld,
    output logic                   cfg_rdy,
    input  logic [PIN_W-1:0]       cfg_pin,
    input  logic [SEL_W-1:0]       cfg_sel,
    input  logic                   cfg_dbg,
    input  logic                   cfg_lock,
    output logic [2*NUM_PIN-1:0]   fun_sel_o,
    output logic [NUM_PIN-1:0]     dbg_en_o,
    output logic [NUM_PIN-1:0]     oe_gate_n,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    if (GUARD_CYC < 1 || GUARD_CYC > 255) begin : g_bad_guard
        $error("GUARD_CYC out of range 1..255");
    end

    localparam logic [GUARD_W-1:0] RELOAD = GUARD_W'(GUARD_CYC - 1);

    state_e state_q, state_d;

    logic [PIN_W-1:0]     pin_q, pin_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 dbg_q, dbg_d;
    logic [2*NUM_PIN-1:0] fun_sel_q, fun_sel_d;
    logic [NUM_PIN-1:0]   dbg_en_q, dbg_en_d;
    logic [NUM_PIN-1:0]   gate_n_q, gate_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;

    logic [31:0]          pin_ext;
    logic [31:0]          pin_q_ext;
    logic                 accept;
    logic                 out_of_range;
    logic                 pin_locked;
    logic [SEL_W-1:0]     cur_sel;
    logic                 cur_dbg;

`ifdef IO_MUX_CTRL_LOCK_EN
    logic [NUM_PIN-1:0]   lock_q, lock_d;
    logic                 lock_req_q, lock_req_d;
`else
    logic                 unused_lock;
    assign unused_lock = cfg_lock;
`endif

    assign pin_ext      = 32'(cfg_pin);
    assign pin_q_ext    = 32'(pin_q);
    assign cfg_rdy      = (state_q == IDLE) && (testmode == 2'b00);
    assign accept       = cfg_vld && cfg_rdy;
    assign out_of_range = (pin_ext >= 32'(NUM_PIN));

    // Current settings of the requested pin, for the no-change shortcut.
    always_comb begin
        cur_sel    = '0;
        cur_dbg    = 1'b0;
        pin_locked = 1'b0;
        for (int k = 0; k < NUM_PIN; k++) begin
            if (pin_ext == 32'(k)) begin
                cur_sel = fun_sel_q[2*k +: 2];
                cur_dbg = dbg_en_q[k];
`ifdef IO_MUX_CTRL_LOCK_EN
                pin_locked = lock_q[k];
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pin_d     = pin_q;
        sel_d     = sel_q;
        dbg_d     = dbg_q;
        fun_sel_d = fun_sel_q;
        dbg_en_d  = dbg_en_q;
        gate_n_d  = gate_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
`ifdef IO_MUX_CTRL_LOCK_EN
        lock_d     = lock_q;
        lock_req_d = lock_req_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (out_of_range || pin_locked) begin
                        err_d = 1'b1;
                    end else if (cfg_sel == cur_sel && cfg_dbg == cur_dbg) begin
                        done_d = 1'b1;
`ifdef IO_MUX_CTRL_LOCK_EN
                        for (int k = 0; k < NUM_PIN; k++) begin
                            if (pin_ext == 32'(k) && cfg_lock) lock_d[k] = 1'b1;
                        end
`endif
                    end else begin
                        state_d  = GATE;
                        pin_d    = cfg_pin;
                        sel_d    = cfg_sel;
                        dbg_d    = cfg_dbg;
                        busy_d   = 1'b1;
                        cnt_load = 1'b1;
`ifdef IO_MUX_CTRL_LOCK_EN
                        lock_req_d = cfg_lock;
`endif
                        for (int k = 0; k < NUM_PIN; k++) begin
                            if (pin_ext == 32'(k)) gate_n_d[k] = 1'b0;
                        end
                    end
                end
            end
            GATE: begin
                if (cnt_zero) begin
                    state_d  = SETTLE;
                    cnt_load = 1'b1;
                    for (int k = 0; k < NUM_PIN; k++) begin
                        if (pin_q_ext == 32'(k)) begin
                            fun_sel_d[2*k +: 2] = sel_q;
                            dbg_en_d[k]         = dbg_q;
`ifdef IO_MUX_CTRL_LOCK_EN
                            if (lock_req_q) lock_d[k] = 1'b1;
`endif
                        end
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    for (int k = 0; k < NUM_PIN; k++) begin
                        if (pin_q_ext == 32'(k)) gate_n_d[k] = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pin_q     <= '0;
            sel_q     <= '0;
            dbg_q     <= 1'b0;
            fun_sel_q <= '0;
            dbg_en_q  <= '0;
            gate_n_q  <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef IO_MUX_CTRL_LOCK_EN
            lock_q     <= '0;
            lock_req_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pin_q     <= pin_d;
            sel_q     <= sel_d;
            dbg_q     <= dbg_d;
            fun_sel_q <= fun_sel_d;
            dbg_en_q  <= dbg_en_d;
            gate_n_q  <= gate_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef IO_MUX_CTRL_LOCK_EN
            lock_q     <= lock_d;
            lock_req_q <= lock_req_d;
`endif
        end
    end

    io_mux_guard_cnt u_guard_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign fun_sel_o = fun_sel_q;
    assign dbg_en_o  = dbg_en_q;
    assign oe_gate_n = gate_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
